// File: rtl/mult_pkg.sv
// Shared encodings and widths for the sequential Booth multiplier.
package mult_pkg;
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam int          MULT_W   = 4;
  localparam int          PROD_W   = 8;
  localparam logic [2:0]  ITER_CNT = 3'd4;
endpackage

// File: rtl/AdderSubtractor4bits.sv
// 4-bit two's-complement adder/subtractor: Sum = A + B (AddSub=0) or A - B (AddSub=1).
module AdderSubtractor4bits (
  input  logic [3:0] A,
  input  logic [3:0] B,
  input  logic       AddSub,
  output logic [3:0] Sum,
  output logic       Overflow,
  output logic       CarryOut
);
  logic [3:0] b_eff;
  logic [4:0] full;

  assign b_eff    = B ^ {4{AddSub}};
  assign full     = {1'b0, A} + {1'b0, b_eff} + {4'b0000, AddSub};
  assign Sum      = full[3:0];
  assign CarryOut = full[4];
  // Signed overflow: operands agree in sign but the result does not.
  assign Overflow = (A[3] == b_eff[3]) && (Sum[3] != A[3]);
endmodule

// File: rtl/booth_multiplier4.sv
// Sequential signed 4x4 radix-2 Booth multiplier built around AdderSubtractor4bits.
// Optional zero flag on the product is enabled by defining MULT_ZERO_FLAG_EN.
module booth_multiplier4
  import mult_pkg::*;
(
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic signed [MULT_W-1:0] a,
  input  logic signed [MULT_W-1:0] b,
  output logic                     busy,
  output logic                     done,
  output logic signed [PROD_W-1:0] product
`ifdef MULT_ZERO_FLAG_EN
  ,
  output logic                     zero
`endif
);
  state_e                    state_q;
  logic signed [MULT_W-1:0]  a_q, m_q;
  logic        [MULT_W-1:0]  q_q;
  logic                      q1_q;
  logic        [2:0]         cnt_q;
  logic                      busy_q, done_q;
  logic signed [PROD_W-1:0]  product_q;

  logic        [MULT_W-1:0]  b_op;
  logic                      add_sub;
  logic        [MULT_W-1:0]  sum;
  logic                      ovf;
  logic                      carry_unused;
  logic signed [MULT_W-1:0]  a_d;
  logic        [MULT_W-1:0]  q_d;
  logic        [2:0]         cnt_d;

  always_comb begin
    b_op    = '0;
    add_sub = 1'b0;
    unique case ({q_q[0], q1_q})
      2'b01:   b_op = m_q;
      2'b10: begin
        b_op    = m_q;
        add_sub = 1'b1;
      end
      default: ;
    endcase
  end

  AdderSubtractor4bits u_addsub (
    .A        (a_q),
    .B        (b_op),
    .AddSub   (add_sub),
    .Sum      (sum),
    .Overflow (ovf),
    .CarryOut (carry_unused)
  );

  // Sum[3]^Overflow is the true sign of the 5-bit result, so M = -8 shifts correctly.
  assign a_d   = {sum[3] ^ ovf, sum[3:1]};
  assign q_d   = {sum[0], q_q[3:1]};
  assign cnt_d = cnt_q - 3'd1;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      a_q       <= '0;
      m_q       <= '0;
      q_q       <= '0;
      q1_q      <= 1'b0;
      cnt_q     <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      product_q <= '0;
`ifdef MULT_ZERO_FLAG_EN
      zero      <= 1'b1;
`endif
    end else begin
      unique case (state_q)
        IDLE: begin
          done_q <= 1'b0;
          if (start) begin
            m_q     <= a;
            q_q     <= b;
            a_q     <= '0;
            q1_q    <= 1'b0;
            cnt_q   <= ITER_CNT;
            busy_q  <= 1'b1;
            state_q <= CALC;
          end
        end
        CALC: begin
          a_q   <= a_d;
          q_q   <= q_d;
          q1_q  <= q_q[0];
          cnt_q <= cnt_d;
          if (cnt_d == 3'd0) begin
            state_q   <= DONE;
            busy_q    <= 1'b0;
            done_q    <= 1'b1;
            product_q <= {a_d, q_d};
`ifdef MULT_ZERO_FLAG_EN
            zero      <= ({a_d, q_d} == '0);
`endif
          end
        end
        DONE: begin
          done_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign product = product_q;
endmodule

// File: doc/booth_multiplier4.md
# booth_multiplier4

Sequential signed 4×4 radix-2 Booth multiplier producing an 8-bit two's-complement product.
- Sits directly upstream of the 4-bit adder/subtractor: each cycle it drives that block's operands and `AddSub` control, then consumes its `Sum` and `Overflow` to form the next partial product.
- Takes one load cycle plus four iteration cycles per multiplication.

## Interface
Parameters:
- none; the width is fixed at 4 because the 4-bit adder/subtractor is reused.

Ports (clock and reset first; one clock; reset is synchronous and active-high):
- `clk`  in  1  — single clock, rising-edge.
- `rst`  in  1  — synchronous, active-high reset.
- `start`  in  1  — request a multiplication; sampled only in IDLE.
- `a`  in  4  — signed multiplicand M; captured on accepted start.
- `b`  in  4  — signed multiplier Q; captured on accepted start.
- `busy`  out  1  — high from the cycle after an accepted start through the final iteration.
- `done`  out  1  — one-cycle pulse; `product` is valid from this cycle.
- `product`  out  8  — signed result; held until the next accepted start completes.
- `zero`  out  1  — present only with `MULT_ZERO_FLAG_EN`; high when `product == 0`.

## Operation
- States: IDLE, CALC, DONE.
  - IDLE → CALC on `start`.
  - CALC → DONE when `count` reaches 0 after the 4th step.
  - DONE → IDLE unconditionally.
- Load, on an accepted start (IDLE and `start`): `M` ← `a`, `Q` ← `b`, `A` ← 0, `Q_1` ← 0, `count` ← 4.
- Each CALC cycle, select on `{Q[0], Q_1}`:
  - 01: A + M, with `AddSub=0`.
  - 10: A − M, with `AddSub=1`.
  - 00 or 11: pass A, driving the adder with B=0 and `AddSub=0`.
- Arithmetic shift right of `{A, Q, Q_1}`:
  - new `A` = `{Sum[3] ^ Overflow, Sum[3:1]}`.
  - new `Q` = `{Sum[0], Q[3:1]}`.
  - new `Q_1` = `Q[0]`.
  - `count` decrements.
- Using `Sum[3] ^ Overflow` as the shifted-in sign bit is mandatory; it makes M = −8 (including −8 × −8) correct.
- On the CALC → DONE transition, `product` ← `{A_next, Q_next}`.
- `start` in CALC or DONE is ignored; it is not queued.
- `a` and `b` are don't-care after load.

## Timing
- Reset values:
  - state = IDLE.
  - `busy` = 0, `done` = 0.
  - `product` = 8'h00; `zero` = 1 when compiled in.
  - `A`, `Q`, `M`, `Q_1`, `count` = 0.
- Latency: with `start` sampled at edge N, steps execute at edges N+1…N+4; `done` = 1 and `product` are valid in the cycle after edge N+4.
- Issue rate: the next start can be accepted at edge N+6, so throughput is one multiply per 6 cycles with back-to-back `start`.
- `busy` = 1 in CALC only; it is 0 in DONE.
- Reset mid-operation: the operation is aborted, all registers return to reset values at that edge, and no `done` is issued.
- `rst` has priority over `start` in the same cycle.

## Configuration
- `MULT_ZERO_FLAG_EN` defined:
  - port `zero` exists, registered alongside `product`.
  - it updates only when `product` updates; reset value 1.
- `MULT_ZERO_FLAG_EN` undefined:
  - no `zero` port or logic.
  - all other behaviour is identical.

## Structure
- Shared package `mult_pkg`:
  - state encodings IDLE=2'd0, CALC=2'd1, DONE=2'd2.
  - `MULT_W`=4, `PROD_W`=8, `ITER_CNT`=3'd4.
- One sub-module instance: the existing `AdderSubtractor4bits`.
  - Connections: A←`A`, B←`M` (or 0 when passing), `AddSub`←select, outputs `Sum` and `Overflow`.
  - Its `CarryOut` is unused.
- The FSM, shift registers and counter live in `booth_multiplier4`.

## Test plan
- Reset then idle for 10 cycles → `busy`=0, `done`=0, `product`=8'h00, `zero`=1.
- `a`=3, `b`=5, pulse `start` → `done` pulses exactly 5 cycles after the start edge, `product`=8'h0F.
- Corner operands:
  - `a`=−8, `b`=−8 → `product`=8'h40.
  - `a`=−8, `b`=7 → 8'hC8.
  - `a`=7, `b`=−1 → 8'hF9.
- `a`=0, `b`=−3 → `product`=8'h00, `zero`=1.
- Hold `start` high continuously with `a`=2, `b`=3 → one result per 6 cycles, `product`=8'h06; mid-CALC operand changes have no effect.
- Assert `rst` during the 2nd CALC cycle → the next cycle shows IDLE, `busy`=0, `product`=8'h00, and no `done` pulse.
- Exhaustive sweep of all 256 (a, b) pairs → `product` equals the signed reference `a*b` every time.
